packetize_send_queue: RTL and testbench

Parametrised successor to the single-channel packetize send controller. It accepts payloads from `N_CH` producers (neuron/PE cores) over 4-phase req/ack, stamps each with its source ID, and buffers the packets in a `DEPTH`-entry FIFO. The FIFO drains to the NoC router's local port over a 4-phase req/ack. Channels are arbitrated round-robin, and optional zero-payload suppression drops empty spike words.

---
 rtl/packetize_pkg.sv | 28 ++
 rtl/pkt_fifo.sv | 54 +++++
 rtl/packetize_send_queue.sv | 183 ++++++++++++++++++
 tb/tb_packetize_send_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packetize_pkg.sv
// Shared widths, packet layout and FSM state types for the packetize send queue.
package packetize_pkg;

    localparam int unsigned PKT_ADDR_W = 4;
    localparam int unsigned PKT_TYPE_W = 3;
    localparam int unsigned PKT_DATA_W = 24;
    localparam int unsigned IN_W       = PKT_ADDR_W + PKT_TYPE_W + PKT_DATA_W;
    localparam int unsigned PKT_W      = 2 * PKT_ADDR_W + PKT_TYPE_W + PKT_DATA_W;

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] dest;
        logic [PKT_ADDR_W-1:0] src;
        logic [PKT_TYPE_W-1:0] ptype;
        logic [PKT_DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic {
        I_IDLE = 1'b0,
        I_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_REL  = 2'd2
    } out_state_e;

endpackage

// File: rtl/pkt_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; head is read combinationally, never bypassed.
module pkt_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/packetize_send_queue.sv
// Multi-channel packetizer: per-channel 4-phase input FSMs, round-robin arbiter, FIFO,
// and a 4-phase output FSM towards the router local port.
module packetize_send_queue
    import packetize_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned TYPE_W    = 3,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned DEPTH     = 4,
    parameter bit          DROP_ZERO = 1'b0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_CH-1:0]                           in_req,
    output logic [N_CH-1:0]                           in_ack,
    input  logic [N_CH*(ADDR_W+TYPE_W+DATA_W)-1:0]    in_data,
    output logic                                      out_req,
    input  logic                                      out_ack,
    output logic [2*ADDR_W+TYPE_W+DATA_W-1:0]         out_pkt,
    output logic [$clog2(DEPTH):0]                    fifo_level,
    output logic [15:0]                               sent_cnt,
    output logic [15:0]                               drop_cnt
);

    localparam int unsigned L_IN_W  = ADDR_W + TYPE_W + DATA_W;
    localparam int unsigned L_PKT_W = 2 * ADDR_W + TYPE_W + DATA_W;
    localparam int unsigned PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    in_state_e            r_in_state     [N_CH];
    in_state_e            w_in_state_nxt [N_CH];
    out_state_e           r_out_state;
    out_state_e           w_out_state_nxt;

    logic [N_CH-1:0]      w_drop;
    logic [N_CH-1:0]      w_elig;
    logic [N_CH-1:0]      w_grant;
    logic                 w_any_grant;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [PTR_W-1:0]     r_rr_ptr;

    logic [L_IN_W-1:0]    w_sel_in;
    logic [ADDR_W-1:0]    w_src;
    logic [L_PKT_W-1:0]   w_push_pkt;
    logic                 w_sel_drop;
    logic                 w_push;
    logic                 w_drop_evt;

    logic [L_PKT_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_load;

    logic [L_PKT_W-1:0]   r_out_pkt;
    logic [15:0]          r_sent_cnt;
    logic [15:0]          r_drop_cnt;

    // Droppable packets bypass the full check since they never occupy a slot.
    always_comb begin
        w_drop = '0;
        w_elig = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_drop[c] = DROP_ZERO && (in_data[c*L_IN_W +: DATA_W] == '0);
            w_elig[c] = (r_in_state[c] == I_IDLE) && in_req[c] && (!w_full || w_drop[c]);
        end
    end

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_any_grant = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + i) % int'(N_CH));
            if (!w_any_grant && w_elig[w_idx]) begin
                w_any_grant        = 1'b1;
                w_grant[w_idx]     = 1'b1;
                w_grant_idx        = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_in   = in_data[w_grant_idx*L_IN_W +: L_IN_W];
        w_src      = ADDR_W'(w_grant_idx);
        w_push_pkt = {w_sel_in[L_IN_W-1 -: ADDR_W], w_src, w_sel_in[TYPE_W+DATA_W-1:0]};
        w_sel_drop = w_drop[w_grant_idx];
        w_push     = w_any_grant && !w_sel_drop;
        w_drop_evt = w_any_grant && w_sel_drop;
    end

    always_comb begin
        in_ack = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_in_state_nxt[c] = r_in_state[c];
            case (r_in_state[c])
                I_IDLE: if (w_grant[c]) w_in_state_nxt[c] = I_ACK;
                I_ACK:  if (!in_req[c]) w_in_state_nxt[c] = I_IDLE;
                default: w_in_state_nxt[c] = I_IDLE;
            endcase
            in_ack[c] = (r_in_state[c] == I_ACK);
        end
    end

    // The head stays in the FIFO until the router releases ack, so level counts it.
    always_comb begin
        w_out_state_nxt = r_out_state;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        out_req         = 1'b0;
        case (r_out_state)
            O_IDLE: begin
                if (!w_empty) begin
                    w_load          = 1'b1;
                    w_out_state_nxt = O_REQ;
                end
            end
            O_REQ: begin
                out_req = 1'b1;
                if (out_ack) w_out_state_nxt = O_REL;
            end
            O_REL: begin
                if (!out_ack) begin
                    w_pop           = 1'b1;
                    w_out_state_nxt = O_IDLE;
                end
            end
            default: w_out_state_nxt = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_in_state[c] <= I_IDLE;
            end
            r_out_state <= O_IDLE;
            r_out_pkt   <= '0;
            r_sent_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_in_state[c] <= w_in_state_nxt[c];
            end
            r_out_state <= w_out_state_nxt;
            if (w_load) begin
                r_out_pkt <= w_head;
            end
            if (w_pop) begin
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end
            if (w_drop_evt) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_any_grant) begin
                r_rr_ptr <= (w_grant_idx == PTR_W'(N_CH - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    pkt_fifo #(
        .WIDTH (L_PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_pkt),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign out_pkt  = r_out_pkt;
    assign sent_cnt = r_sent_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_packetize_send_queue.sv
// Self-checking bench: table-driven single sends, scoreboard on out_pkt, hand-written corners.
module tb_packetize_send_queue;
    import packetize_pkg::*;

    localparam int NC = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NC-1:0]        in_req;
    logic [NC-1:0]        in_ack;
    logic [NC*IN_W-1:0]   in_data;
    logic                 out_req;
    logic                 out_ack;
    logic [PKT_W-1:0]     out_pkt;
    logic [2:0]           fifo_level;
    logic [15:0]          sent_cnt;
    logic [15:0]          drop_cnt;

    logic [NC-1:0]        dz_in_req;
    logic [NC-1:0]        dz_in_ack;
    logic [NC*IN_W-1:0]   dz_in_data;
    logic                 dz_out_req;
    wire                  dz_out_ack;
    logic [PKT_W-1:0]     dz_out_pkt;
    logic [2:0]           dz_fifo_level;
    logic [15:0]          dz_sent_cnt;
    logic [15:0]          dz_drop_cnt;

    assign dz_out_ack = dz_out_req;

    packetize_send_queue dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_pkt(out_pkt), .fifo_level(fifo_level),
        .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
    );

    packetize_send_queue #(.DROP_ZERO(1'b1)) dut_dz (
        .clk(clk), .rst(rst), .in_req(dz_in_req), .in_ack(dz_in_ack), .in_data(dz_in_data),
        .out_req(dz_out_req), .out_ack(dz_out_ack), .out_pkt(dz_out_pkt),
        .fifo_level(dz_fifo_level), .sent_cnt(dz_sent_cnt), .drop_cnt(dz_drop_cnt)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [PKT_W-1:0] sb_q[$];
    logic             router_en = 1'b0;
    logic             mon_prev = 1'b0;

    typedef struct {
        int                    ch;
        logic [PKT_ADDR_W-1:0] dest;
        logic [PKT_TYPE_W-1:0] typ;
        logic [PKT_DATA_W-1:0] data;
        logic [PKT_W-1:0]      exp;
    } vec_t;

    vec_t vt[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input logic [3:0] d, input logic [3:0] s,
                                             input logic [2:0] t, input logic [23:0] x);
        pkt_t p;
        p.dest  = d;
        p.src   = s;
        p.ptype = t;
        p.data  = x;
        return p;
    endfunction

    task automatic set_in(input int ch, input logic [3:0] d, input logic [2:0] t,
                          input logic [23:0] x);
        in_data[ch*IN_W +: IN_W] = {d, t, x};
    endtask

    task automatic send(input int ch, input logic [3:0] d, input logic [2:0] t,
                        input logic [23:0] x);
        int n;
        set_in(ch, d, t, x);
        in_req[ch] = 1'b1;
        n = 0;
        while (!in_ack[ch] && n < 300) begin
            tick();
            n++;
        end
        check("send_ack_seen", {63'd0, in_ack[ch]}, 64'd1);
        in_req[ch] = 1'b0;
        n = 0;
        while (in_ack[ch] && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(fifo_level == 0 && !out_req && !out_ack) && n < 400) begin
            tick();
            n++;
        end
        check("drain_done", {63'd0, (fifo_level == 0 && !out_req && !out_ack)}, 64'd1);
    endtask

    // Router model: follows out_req one cycle later when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (router_en) out_ack = out_req;
        end
    end

    // Scoreboard: each new out_req presentation pops one expected packet.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_req && !mon_prev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no packet", out_pkt);
                end else begin
                    check("sb_pkt", {29'd0, out_pkt}, {29'd0, sb_q.pop_front()});
                end
            end
            mon_prev = out_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;

        vt[0] = '{2, 4'hA, 3'd5, 24'hABCDEF, {4'hA, 4'd2, 3'd5, 24'hABCDEF}};
        vt[1] = '{1, 4'h0, 3'd7, 24'h800001, {4'h0, 4'd1, 3'd7, 24'h800001}};
        vt[2] = '{3, 4'hF, 3'd0, 24'h000000, {4'hF, 4'd3, 3'd0, 24'h000000}};

        rst        = 1'b1;
        in_req     = '0;
        in_data    = '0;
        out_ack    = 1'b0;
        dz_in_req  = '0;
        dz_in_data = '0;
        repeat (2) tick();
        check("rst_in_ack", in_ack, 0);
        check("rst_out_req", out_req, 0);
        check("rst_out_pkt", out_pkt, 0);
        check("rst_level", fifo_level, 0);
        check("rst_sent", sent_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Test 1: single channel 0, latency and drain.
        router_en = 1'b1;
        set_in(0, 4'd3, 3'd1, 24'h00000F);
        sb_q.push_back({4'd3, 4'd0, 3'd1, 24'h00000F});
        in_req[0] = 1'b1;
        tick();
        check("t1_ack_after_1", in_ack, 4'b0001);
        check("t1_level_1", fifo_level, 1);
        check("t1_no_bypass", out_req, 0);
        in_req[0] = 1'b0;
        tick();
        check("t1_req_after_2", out_req, 1);
        check("t1_ack_fall", in_ack, 0);
        check("t1_pkt", out_pkt, {29'd0, 4'd3, 4'd0, 3'd1, 24'h00000F});
        wait_drain();
        check("t1_sent", sent_cnt, 1);
        check("t1_level_0", fifo_level, 0);

        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(vt[i].exp);
            send(vt[i].ch, vt[i].dest, vt[i].typ, vt[i].data);
            wait_drain();
            check("tbl_sent", sent_cnt, 64'(2 + i));
        end

        // Test 2: all channels at once; pointer is 0 after channel 3's grant.
        for (int c = 0; c < NC; c++) begin
            set_in(c, 4'(c + 4), 3'(c), 24'(24'h100 + c));
            sb_q.push_back(mk(4'(c + 4), 4'(c), 3'(c), 24'(24'h100 + c)));
        end
        in_req = 4'b1111;
        for (int k = 0; k < NC; k++) begin
            tick();
            check("t2_grant_order", in_ack, 64'(1) << k);
            in_req[k] = 1'b0;
        end
        tick();
        check("t2_ack_clear", in_ack, 0);
        wait_drain();
        check("t2_sent", sent_cnt, 8);

        // Test 3: router stalled, 6 requests into a 4-deep FIFO.
        router_en = 1'b0;
        for (int c = 0; c < NC; c++) begin
            set_in(c, 4'(c), 3'd2, 24'(24'h5500 + c));
            sb_q.push_back(mk(4'(c), 4'(c), 3'd2, 24'(24'h5500 + c)));
        end
        in_req = 4'b1111;
        for (int k = 0; k < NC; k++) begin
            tick();
            check("t3_grant_order", in_ack, 64'(1) << k);
            in_req[k] = 1'b0;
        end
        set_in(0, 4'h9, 3'd3, 24'hC0FFEE);
        set_in(1, 4'h8, 3'd4, 24'h00BEEF);
        sb_q.push_back(mk(4'h9, 4'd0, 3'd3, 24'hC0FFEE));
        sb_q.push_back(mk(4'h8, 4'd1, 3'd4, 24'h00BEEF));
        in_req[1:0] = 2'b11;
        repeat (8) tick();
        check("t3_stalled_ack", in_ack, 0);
        check("t3_level_full", fifo_level, 4);
        router_en = 1'b1;
        n = 0;
        while (in_req != 0 && n < 400) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (in_ack[c]) in_req[c] = 1'b0;
            end
            n++;
        end
        check("t3_stall_release", in_req, 0);
        wait_drain();
        check("t3_sent", sent_cnt, 14);

        // Test 4: zero payload dropped on the DROP_ZERO instance.
        dz_in_data[2*IN_W +: IN_W] = {4'd5, 3'd1, 24'h000000};
        dz_in_req[2] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!dz_in_ack[2] && n < 20) begin
            tick();
            seen |= dz_out_req;
            n++;
        end
        check("t4_ack", dz_in_ack[2], 1);
        dz_in_req[2] = 1'b0;
        repeat (4) begin
            tick();
            seen |= dz_out_req;
        end
        check("t4_ack_fall", dz_in_ack, 0);
        check("t4_level", dz_fifo_level, 0);
        check("t4_drop_cnt", dz_drop_cnt, 1);
        check("t4_no_out_req", seen, 0);
        dz_in_data[1*IN_W +: IN_W] = {4'd6, 3'd2, 24'h000001};
        dz_in_req[1] = 1'b1;
        n = 0;
        while (!dz_in_ack[1] && n < 20) begin
            tick();
            n++;
        end
        dz_in_req[1] = 1'b0;
        n = 0;
        while (dz_sent_cnt == 0 && n < 40) begin
            tick();
            n++;
        end
        check("t4_nonzero_sent", dz_sent_cnt, 1);
        check("t4_nonzero_pkt", dz_out_pkt, {29'd0, 4'd6, 4'd1, 3'd2, 24'h000001});
        check("t4_drop_hold", dz_drop_cnt, 1);

        // Test 5: reset mid-handshake.
        router_en = 1'b0;
        set_in(1, 4'h7, 3'd6, 24'h123456);
        sb_q.push_back(mk(4'h7, 4'd1, 3'd6, 24'h123456));
        in_req[1] = 1'b1;
        tick();
        check("t5_ack", in_ack, 4'b0010);
        tick();
        check("t5_out_req", out_req, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_ack", in_ack, 0);
        check("t5_rst_req", out_req, 0);
        check("t5_rst_sent", sent_cnt, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_dz_drop", dz_drop_cnt, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        sb_q.push_back(mk(4'h7, 4'd1, 3'd6, 24'h123456));
        n = 0;
        while (!in_ack[1] && n < 2) begin
            tick();
            n++;
        end
        check("t5_reack", in_ack[1], 1);
        in_req[1] = 1'b0;
        router_en = 1'b1;
        wait_drain();
        check("t5_sent", sent_cnt, 1);

        // Test 6: simultaneous push and pop at level 2, then across index wrap.
        router_en = 1'b0;
        out_ack   = 1'b0;
        sb_q.push_back(mk(4'h1, 4'd0, 3'd1, 24'hAAAAAA));
        send(0, 4'h1, 3'd1, 24'hAAAAAA);
        sb_q.push_back(mk(4'h2, 4'd1, 3'd2, 24'hBBBBBB));
        send(1, 4'h2, 3'd2, 24'hBBBBBB);
        n = 0;
        while (!out_req && n < 20) begin
            tick();
            n++;
        end
        check("t6_req_up", out_req, 1);
        check("t6_level_2", fifo_level, 2);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        set_in(2, 4'h3, 3'd3, 24'hCCCCCC);
        sb_q.push_back(mk(4'h3, 4'd2, 3'd3, 24'hCCCCCC));
        in_req[2] = 1'b1;
        tick();
        check("t6_level_same", fifo_level, 2);
        check("t6_push_ack", in_ack, 4'b0100);
        check("t6_pop_sent", sent_cnt, 2);
        in_req[2] = 1'b0;
        router_en = 1'b1;
        sb_q.push_back(mk(4'h4, 4'd3, 3'd4, 24'hDDDDDD));
        send(3, 4'h4, 3'd4, 24'hDDDDDD);
        wait_drain();
        check("t6_sent", sent_cnt, 5);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
